// File: rtl/pixel_byte_feeder.sv
// pixel_byte_feeder: takes 24-bit RGB pixels over valid/ready and emits them
// as three bytes (MSB first), tagged with the pixel's column and line.
// Optional feature macro: FEEDER_SOF_RESYNC_EN (pix_sof forces position (0,0)).
module pixel_byte_feeder #(
    parameter int unsigned H_PIXELS = 110,
    parameter int unsigned V_LINES  = 110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pix_in,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic        out_ready,
    output logic [7:0]  FrameIn,
    output logic        byte_valid,
    output logic [1:0]  byte_idx,
    output logic [9:0]  PxOut,
    output logic [9:0]  LineOut,
    output logic        frame_done,
    output logic        sof_err
);

    localparam logic [9:0] LAST_PX   = 10'(H_PIXELS - 1);
    localparam logic [9:0] LAST_LINE = 10'(V_LINES - 1);

    typedef enum logic [1:0] {EMPTY, B0, B1, B2} state_t;

    state_t      state, stateNext;
    logic [23:0] holdReg;
    logic [9:0]  pxReg, lineReg;
    logic [9:0]  pxAdv, lineAdv;
    logic        firstPix;
    logic        readyEn;
    logic        accept;
    logic        sofHit;
    logic        frameDoneReg;

    assign accept     = pix_valid && pix_ready;
    assign PxOut      = pxReg;
    assign LineOut    = lineReg;
    assign frame_done = frameDoneReg;

    // Handshake, byte selection and next-state decode
    always_comb begin
        stateNext  = state;
        FrameIn    = '0;
        byte_idx   = '0;
        byte_valid = 1'b0;
        pix_ready  = readyEn && ((state == EMPTY) || ((state == B2) && out_ready));
        case (state)
            EMPTY: begin
                if (pix_valid && pix_ready) stateNext = B0;
            end
            B0: begin
                FrameIn    = holdReg[23:16];
                byte_idx   = 2'd0;
                byte_valid = 1'b1;
                if (out_ready) stateNext = B1;
            end
            B1: begin
                FrameIn    = holdReg[15:8];
                byte_idx   = 2'd1;
                byte_valid = 1'b1;
                if (out_ready) stateNext = B2;
            end
            B2: begin
                FrameIn    = holdReg[7:0];
                byte_idx   = 2'd2;
                byte_valid = 1'b1;
                if (out_ready) stateNext = (pix_valid && pix_ready) ? B0 : EMPTY;
            end
            default: stateNext = EMPTY;
        endcase
    end

    // Position the next accepted pixel would take without resync
    always_comb begin
        pxAdv   = '0;
        lineAdv = '0;
        if (!firstPix) begin
            if (pxReg == LAST_PX) begin
                pxAdv   = '0;
                lineAdv = (lineReg == LAST_LINE) ? '0 : lineReg + 10'd1;
            end else begin
                pxAdv   = pxReg + 10'd1;
                lineAdv = lineReg;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= stateNext;
    end

    // pix_ready is held off until the first edge after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) readyEn <= 1'b0;
        else        readyEn <= 1'b1;
    end

    // Pixel capture and position tracking on acceptance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            holdReg  <= '0;
            pxReg    <= '0;
            lineReg  <= '0;
            firstPix <= 1'b1;
        end else if (accept) begin
            holdReg  <= pix_in;
            firstPix <= 1'b0;
            if (sofHit) begin
                pxReg   <= '0;
                lineReg <= '0;
            end else begin
                pxReg   <= pxAdv;
                lineReg <= lineAdv;
            end
        end
    end

    // Frame-complete pulse, registered off the edge that takes the last byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frameDoneReg <= 1'b0;
        else        frameDoneReg <= (state == B2) && out_ready &&
                                    (pxReg == LAST_PX) && (lineReg == LAST_LINE);
    end

`ifdef FEEDER_SOF_RESYNC_EN
    logic sofErrReg;

    assign sofHit  = pix_sof && ((pxAdv != '0) || (lineAdv != '0));
    assign sof_err = sofErrReg;

    // Flag a start-of-frame that arrived away from position (0,0)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sofErrReg <= 1'b0;
        else        sofErrReg <= accept && sofHit;
    end
`else
    logic unusedSof;

    assign unusedSof = pix_sof;
    assign sofHit    = 1'b0;
    assign sof_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_byte_feeder.sv
// Scoreboard bench for pixel_byte_feeder: expected bytes and positions are
// queued when a pixel is accepted and checked as the DUT emits them.
`timescale 1ns/1ps
module tb_pixel_byte_feeder;

    localparam int unsigned H = 110;
    localparam int unsigned V = 110;

    logic        clk;
    logic        reset;
    logic [23:0] pix_in;
    logic        pix_valid;
    logic        pix_sof;
    logic        pix_ready;
    logic        out_ready;
    logic [7:0]  FrameIn;
    logic        byte_valid;
    logic [1:0]  byte_idx;
    logic [9:0]  PxOut;
    logic [9:0]  LineOut;
    logic        frame_done;
    logic        sof_err;

    pixel_byte_feeder #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .out_ready(out_ready),
        .FrameIn(FrameIn), .byte_valid(byte_valid), .byte_idx(byte_idx),
        .PxOut(PxOut), .LineOut(LineOut), .frame_done(frame_done),
        .sof_err(sof_err)
    );

    typedef struct {
        logic [7:0] b;
        logic [1:0] idx;
        logic [9:0] px;
        logic [9:0] ln;
        bit         last;
    } sbItem_t;

    sbItem_t     sbq[$];
    int          assertCount = 0;
    int          failCount   = 0;
    int          cycleCnt    = 0;
    int          expSofCycle = -1;
    int          lastAcceptCycle = 0;
    int          fdCount     = 0;
    int unsigned mCount      = 0;
    bit          monitorOn   = 0;
    bit          expFd       = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pulses every cycle, bytes whenever one is taken
    always @(negedge clk) begin
        sbItem_t it;
        if (!monitorOn) begin
            expFd = 0;
        end else begin
            checkVal("frame_done", {31'd0, frame_done}, {31'd0, expFd});
            expFd = 0;
            if (frame_done) fdCount++;
            checkVal("sof_err", {31'd0, sof_err}, {31'd0, (cycleCnt == expSofCycle)});
            if (byte_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checkVal("sb_empty_on_byte", {31'd0, byte_valid}, 32'd0);
                end else begin
                    it = sbq.pop_front();
                    checkVal("byte", {2'd0, FrameIn, byte_idx, PxOut, LineOut},
                             {2'd0, it.b, it.idx, it.px, it.ln});
                    expFd = it.last;
                end
            end
        end
    end

    task automatic pushExpected(input logic [23:0] pix, input logic sof);
        int unsigned pos;
        logic [9:0]  px, ln;
        sbItem_t     it;
        pos = mCount % (H * V);
`ifdef FEEDER_SOF_RESYNC_EN
        if (sof && pos != 0) begin
            mCount      = 0;
            pos         = 0;
            expSofCycle = cycleCnt;
        end
`else
        if (sof) pos = pos;
`endif
        px = 10'(pos % H);
        ln = 10'(pos / H);
        mCount++;
        for (int unsigned k = 0; k < 3; k++) begin
            it.b    = pix[23 - 8*k -: 8];
            it.idx  = 2'(k);
            it.px   = px;
            it.ln   = ln;
            it.last = (k == 2) && (px == 10'(H-1)) && (ln == 10'(V-1));
            sbq.push_back(it);
        end
    endtask

    task automatic sendPixel(input logic [23:0] pix, input logic sof);
        int waitCnt;
        bit done;
        pix_in    = pix;
        pix_sof   = sof;
        pix_valid = 1'b1;
        done      = 0;
        waitCnt   = 0;
        while (!done && waitCnt < 200) begin
            @(negedge clk);
            if (pix_ready) begin
                @(posedge clk);
                #1;
                lastAcceptCycle = cycleCnt;
                pushExpected(pix, sof);
                done = 1;
            end else begin
                waitCnt++;
            end
        end
        if (!done) checkVal("accept_timeout", {31'd0, pix_ready}, 32'd1);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300 && sbq.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checkVal("drain", sbq.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        monitorOn   = 0;
        reset       = 1'b0;
        pix_valid   = 1'b0;
        pix_sof     = 1'b0;
        #1;
        checkVal("reset_outputs",
                 {8'd0, FrameIn, byte_valid, byte_idx, PxOut, LineOut,
                  frame_done, sof_err, pix_ready}, 32'd0);
        sbq.delete();
        mCount      = 0;
        expSofCycle = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkVal("ready_before_edge", {31'd0, pix_ready}, 32'd0);
        @(posedge clk);
        #1;
        checkVal("ready_after_edge", {31'd0, pix_ready}, 32'd1);
        monitorOn = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int firstAcc;
        int fdBase;
        logic [23:0] pixS;
        reset     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        out_ready = 1'b1;

        // Single pixel, then idle
        doReset();
        sendPixel(24'hA1B2C3, 1'b0);
        waitDrain();
        checkVal("idle_byte_valid", {31'd0, byte_valid}, 32'd0);

        // Full frame plus one, back-to-back
        doReset();
        fdBase = fdCount;
        sendPixel($urandom, 1'b0);
        firstAcc = lastAcceptCycle;
        for (int i = 1; i < int'(H); i++) sendPixel($urandom, 1'b0);
        checkVal("line_throughput", lastAcceptCycle - firstAcc, 3 * (H - 1));
        for (int i = int'(H); i < int'(H * V); i++) sendPixel($urandom, 1'b0);
        checkVal("frame_throughput", lastAcceptCycle - firstAcc, 3 * (H * V - 1));
        sendPixel(24'h102030, 1'b0);
        waitDrain();
        checkVal("frame_done_count", fdCount - fdBase, 32'd1);

        // Back-pressure during B1 of pixel (1,0)
        pixS = 24'h5A6B7C;
        sendPixel(pixS, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkVal("stall_byte", {22'd0, FrameIn, byte_idx}, {22'd0, pixS[15:8], 2'd1});
            checkVal("stall_ready", {31'd0, pix_ready}, 32'd0);
            checkVal("stall_pos", {12'd0, PxOut, LineOut}, {12'd0, 10'd1, 10'd0});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        waitDrain();

        // Start-of-frame handling: natural SOF, then out-of-place SOF
        doReset();
        sendPixel(24'h000001, 1'b1);
        for (int i = 1; i < 7; i++) sendPixel(24'(i * 24'h010101), 1'b0);
        sendPixel(24'hC0FFEE, 1'b1);
        sendPixel(24'hBEEF01, 1'b0);
        waitDrain();

        // Reset in B1 of pixel (5,3), then restart from (0,0)
        doReset();
        for (int i = 0; i < int'(3 * H + 5); i++) sendPixel($urandom, 1'b0);
        sendPixel(24'h777777, 1'b0);
        @(posedge clk);
        #1;
        doReset();
        sendPixel(24'h123456, 1'b0);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
